// File: rtl/screen_sequencer.sv
// Screen-flow controller for the OLED voice game: menu pages, mic check, volume recording, countdown, play.
// Optional back-navigation on btnL is enabled by defining SCREEN_SEQ_BACKNAV_EN.
module screen_sequencer #(
  parameter  int unsigned MENU_PAGES    = 3,
  parameter  int unsigned VOL_W         = 5,
  parameter  int unsigned VOL_THRESHOLD = 3,
  parameter  int unsigned HIST_DEPTH    = 16,
  parameter  int unsigned SAMPLE_DIV    = 1_000_000,
  parameter  int unsigned TICK_DIV      = 100_000_000,
  parameter  int unsigned COUNTDOWN     = 5,
  localparam int unsigned HC_W          = $clog2(HIST_DEPTH + 1),
  localparam int unsigned HA_W          = $clog2(HIST_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             btnL,
  input  logic             btnR,
  input  logic             btnC,
  input  logic [VOL_W-1:0] volume,
  output logic [2:0]       state,
  output logic [2:0]       page,
  output logic [2:0]       countdown_val,
  output logic [HC_W-1:0]  hist_count,
  input  logic [HA_W-1:0]  hist_rd_addr,
  output logic [VOL_W-1:0] hist_rd_data,
  output logic             play_start
);

  localparam int unsigned SC_W = $clog2(SAMPLE_DIV + 1);
  localparam int unsigned TC_W = $clog2(TICK_DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_MENU       = 3'd1,
    S_MIC_WAIT   = 3'd2,
    S_MIC_VOLUME = 3'd3,
    S_REC_ARM    = 3'd4,
    S_REC        = 3'd5,
    S_COUNT      = 3'd6,
    S_PLAY       = 3'd7
  } state_t;

  state_t            st;
  logic [SC_W-1:0]   scnt;
  logic [TC_W-1:0]   tcnt;
  logic [VOL_W-1:0]  hist [HIST_DEPTH];
  logic              clr;
  logic              r_s1, r_s2, r_q, r_pulse;
  logic              c_s1, c_s2;
  logic              l_pulse;
  logic              sample_hit, tick_hit;

  assign clr = !rst_n || !en;

  // Button synchronisers; btnR gets a registered rising-edge pulse, btnC stays a level
  always_ff @(posedge clk) begin
    if (clr) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_q     <= 1'b0;
      r_pulse <= 1'b0;
      c_s1    <= 1'b0;
      c_s2    <= 1'b0;
    end else begin
      r_s1    <= btnR;
      r_s2    <= r_s1;
      r_q     <= r_s2;
      r_pulse <= r_s2 & ~r_q;
      c_s1    <= btnC;
      c_s2    <= c_s1;
    end
  end

`ifdef SCREEN_SEQ_BACKNAV_EN
  logic l_s1, l_s2, l_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      l_s1    <= 1'b0;
      l_s2    <= 1'b0;
      l_q     <= 1'b0;
      l_pulse <= 1'b0;
    end else begin
      l_s1    <= btnL;
      l_s2    <= l_s1;
      l_q     <= l_s2;
      l_pulse <= l_s2 & ~l_q;
    end
  end
`else
  logic unused_btnl;
  assign unused_btnl = btnL;
  assign l_pulse     = 1'b0;
`endif

  assign sample_hit = (scnt == SC_W'(SAMPLE_DIV - 1));
  assign tick_hit   = (tcnt == TC_W'(TICK_DIV - 1));

  // Screen flow, recording buffer and countdown
  always_ff @(posedge clk) begin
    if (clr) begin
      st            <= S_IDLE;
      page          <= 3'd0;
      countdown_val <= 3'(COUNTDOWN);
      hist_count    <= '0;
      play_start    <= 1'b0;
      scnt          <= '0;
      tcnt          <= '0;
      for (int i = 0; i < int'(HIST_DEPTH); i++) hist[i] <= '0;
    end else begin
      play_start <= 1'b0;
      case (st)
        S_IDLE: begin
          st   <= S_MENU;
          page <= 3'd0;
        end
        S_MENU: begin
          if (r_pulse && !l_pulse) begin
            if (page < 3'(MENU_PAGES - 1)) page <= page + 3'd1;
            else                            st   <= S_MIC_WAIT;
          end else if (l_pulse && !r_pulse && page != 3'd0) begin
            page <= page - 3'd1;
          end
        end
        S_MIC_WAIT: begin
          if (volume > VOL_W'(VOL_THRESHOLD)) begin
            st <= S_MIC_VOLUME;
          end else if (l_pulse) begin
            st   <= S_MENU;
            page <= 3'(MENU_PAGES - 1);
          end
        end
        S_MIC_VOLUME: begin
          if (r_pulse) begin
            st <= S_REC_ARM;
          end else if (l_pulse) begin
            st   <= S_MENU;
            page <= 3'(MENU_PAGES - 1);
          end
        end
        S_REC_ARM: begin
          hist_count <= '0;
          for (int i = 0; i < int'(HIST_DEPTH); i++) hist[i] <= '0;
          if (c_s2) begin
            st   <= S_REC;
            scnt <= '0;
          end
        end
        S_REC: begin
          scnt <= sample_hit ? '0 : scnt + SC_W'(1);
          if (sample_hit && hist_count < HC_W'(HIST_DEPTH)) begin
            for (int i = int'(HIST_DEPTH) - 1; i > 0; i--) hist[i] <= hist[i-1];
            hist[0]    <= volume;
            hist_count <= hist_count + HC_W'(1);
          end
          // a strobe in the release cycle is still written above before leaving
          if (!c_s2 || hist_count == HC_W'(HIST_DEPTH)) begin
            st            <= S_COUNT;
            countdown_val <= 3'(COUNTDOWN);
            tcnt          <= '0;
          end
        end
        S_COUNT: begin
          if (tick_hit) begin
            tcnt <= '0;
            if (countdown_val > 3'd1) begin
              countdown_val <= countdown_val - 3'd1;
            end else begin
              countdown_val <= 3'd0;
              st            <= S_PLAY;
              play_start    <= 1'b1;
            end
          end else begin
            tcnt <= tcnt + TC_W'(1);
          end
        end
        S_PLAY: begin
          st <= S_PLAY;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign state        = st;
  assign hist_rd_data = (32'(hist_rd_addr) < HIST_DEPTH) ? hist[hist_rd_addr] : '0;

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench for screen_sequencer: stimulus schedules expected outputs per cycle, a monitor checks them.
module tb_screen_sequencer;

  localparam int ST = 0, PG = 1, CD = 2, HC = 3, PS = 4, RD = 5;

  logic       clk = 1'b0;
  logic       rst_n, en, btnL, btnR, btnC;
  logic [4:0] volume;
  logic [2:0] state, page, countdown_val;
  logic [2:0] hist_count;
  logic [1:0] hist_rd_addr;
  logic [4:0] hist_rd_data;
  logic       play_start;

  typedef struct {
    int cyc;
    int sel;
    int val;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  screen_sequencer #(
    .MENU_PAGES(3), .VOL_W(5), .VOL_THRESHOLD(3), .HIST_DEPTH(4),
    .SAMPLE_DIV(4), .TICK_DIV(10), .COUNTDOWN(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .btnL(btnL), .btnR(btnR), .btnC(btnC),
    .volume(volume), .state(state), .page(page), .countdown_val(countdown_val),
    .hist_count(hist_count), .hist_rd_addr(hist_rd_addr), .hist_rd_data(hist_rd_data),
    .play_start(play_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      ST:      return 32'(state);
      PG:      return 32'(page);
      CD:      return 32'(countdown_val);
      HC:      return 32'(hist_count);
      PS:      return 32'(play_start);
      default: return 32'(hist_rd_data);
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      ST:      return "state";
      PG:      return "page";
      CD:      return "countdown_val";
      HC:      return "hist_count";
      PS:      return "play_start";
      default: return "hist_rd_data";
    endcase
  endfunction

  // Monitor: compare every expectation scheduled for this cycle
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc == cyc) begin
        n_checks++;
        if (actual(q[i].sel) !== 32'(q[i].val)) begin
          n_fail++;
          $display("FAIL %s @cycle %0d: got %0d, expected %0d",
                   sel_name(q[i].sel), cyc, actual(q[i].sel), q[i].val);
        end
        q.delete(i);
      end else if (q[i].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s missed cycle %0d, expected %0d", sel_name(q[i].sel), q[i].cyc, q[i].val);
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int d, input int sel, input int v);
    exp_t e;
    e.cyc = cyc + d;
    e.sel = sel;
    e.val = v;
    q.push_back(e);
  endtask

  // which: 0=btnL, 1=btnR, 2=both; held two cycles then released
  task automatic pulse_btn(input int which);
    btnL = (which != 1);
    btnR = (which != 0);
    tick;
    tick;
    btnL = 1'b0;
    btnR = 1'b0;
    repeat (4) tick;
  endtask

  task automatic advance_to_rec_arm;
    rst_n  = 1'b0;
    btnC   = 1'b0;
    volume = 5'd0;
    tick;
    tick;
    rst_n = 1'b1;
    en    = 1'b1;
    tick;
    repeat (3) pulse_btn(1);
    volume = 5'd4;
    tick;
    tick;
    volume = 5'd0;
    pulse_btn(1);
    push_exp(0, ST, 4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; btnL = 1'b0; btnR = 1'b0; btnC = 1'b0;
    volume = 5'd0; hist_rd_addr = 2'd0;
    repeat (3) tick;
    push_exp(0, ST, 0); push_exp(0, PG, 0); push_exp(0, CD, 5);
    push_exp(0, HC, 0); push_exp(0, PS, 0); push_exp(0, RD, 0);

    rst_n = 1'b1;
    en    = 1'b1;
    push_exp(0, ST, 0); push_exp(1, ST, 1); push_exp(1, PG, 0);
    tick;
    tick;

    // menu walk: each update lands on the 4th edge after the press
    push_exp(3, PG, 0); push_exp(4, PG, 1);
    pulse_btn(1);
    push_exp(3, PG, 1); push_exp(4, PG, 2);
    pulse_btn(1);
`ifdef SCREEN_SEQ_BACKNAV_EN
    push_exp(4, PG, 1);
    pulse_btn(0);
    push_exp(4, PG, 1); push_exp(6, PG, 1); push_exp(6, ST, 1);
    pulse_btn(2);
    push_exp(4, PG, 2);
    pulse_btn(1);
`else
    push_exp(4, PG, 2); push_exp(6, ST, 1);
    pulse_btn(0);
`endif
    push_exp(3, ST, 1); push_exp(4, ST, 2);
    pulse_btn(1);

    // threshold is strict
    volume = 5'd3;
    push_exp(50, ST, 2); push_exp(100, ST, 2);
    repeat (100) tick;
    volume = 5'd4;
    push_exp(0, ST, 2); push_exp(1, ST, 3);
    tick;
`ifdef SCREEN_SEQ_BACKNAV_EN
    push_exp(4, ST, 1); push_exp(4, PG, 2);
    pulse_btn(0);
    push_exp(4, ST, 2); push_exp(5, ST, 3);
    pulse_btn(1);
`endif
    push_exp(4, ST, 4);
    pulse_btn(1);
    push_exp(0, HC, 0);

    // full recording, countdown and play
    btnC   = 1'b1;
    volume = 5'd1;
    push_exp(2, ST, 4);  push_exp(3, ST, 5);  push_exp(6, HC, 0);  push_exp(7, HC, 1);
    push_exp(11, HC, 2); push_exp(15, HC, 3); push_exp(19, HC, 4); push_exp(19, ST, 5);
    push_exp(20, ST, 6); push_exp(20, CD, 5); push_exp(29, CD, 5); push_exp(30, CD, 4);
    push_exp(40, CD, 3); push_exp(50, CD, 2); push_exp(60, CD, 1); push_exp(69, CD, 1);
    push_exp(69, ST, 6); push_exp(69, PS, 0); push_exp(70, CD, 0); push_exp(70, ST, 7);
    push_exp(70, PS, 1); push_exp(71, PS, 0); push_exp(71, ST, 7);
    for (int i = 1; i <= 75; i++) begin
      tick;
      if (i == 7)  volume = 5'd2;
      if (i == 11) volume = 5'd3;
      if (i == 15) volume = 5'd4;
      if (i == 19) volume = 5'd5;
    end
    push_exp(0, HC, 4);
    for (int a = 0; a < 4; a++) begin
      hist_rd_addr = 2'(a);
      push_exp(0, RD, 4 - a);
      tick;
    end

    // early release after two samples, then en drop mid-countdown
    advance_to_rec_arm();
    btnC = 1'b1; volume = 5'd7; hist_rd_addr = 2'd0;
    push_exp(7, HC, 1);  push_exp(13, ST, 5); push_exp(14, ST, 6); push_exp(14, HC, 2);
    push_exp(14, CD, 5); push_exp(15, RD, 7); push_exp(24, CD, 4); push_exp(34, CD, 3);
    push_exp(39, CD, 3); push_exp(39, ST, 6); push_exp(40, ST, 0); push_exp(40, CD, 5);
    push_exp(40, HC, 0); push_exp(40, PG, 0); push_exp(40, PS, 0); push_exp(40, RD, 0);
    push_exp(41, ST, 1);
    for (int i = 1; i <= 42; i++) begin
      tick;
      if (i == 11) btnC = 1'b0;
      if (i == 39) en = 1'b0;
      if (i == 40) en = 1'b1;
    end

    // release coinciding with a strobe: sample kept, then exit
    advance_to_rec_arm();
    btnC = 1'b1; volume = 5'd9; hist_rd_addr = 2'd0;
    push_exp(11, HC, 2); push_exp(14, ST, 5); push_exp(15, ST, 6);
    push_exp(15, HC, 3); push_exp(16, RD, 9);
    for (int i = 1; i <= 17; i++) begin
      tick;
      if (i == 12) btnC = 1'b0;
    end
    hist_rd_addr = 2'd2;
    push_exp(0, RD, 9);
    tick;
    hist_rd_addr = 2'd3;
    push_exp(0, RD, 0);
    tick;

    // one-cycle reset mid-recording
    advance_to_rec_arm();
    btnC = 1'b1; volume = 5'd6; hist_rd_addr = 2'd0;
    push_exp(7, HC, 1);  push_exp(9, RD, 6);  push_exp(9, ST, 5);  push_exp(10, ST, 0);
    push_exp(10, PG, 0); push_exp(10, CD, 5); push_exp(10, HC, 0); push_exp(10, PS, 0);
    push_exp(10, RD, 0); push_exp(11, ST, 1);
    for (int i = 1; i <= 12; i++) begin
      tick;
      if (i == 9) rst_n = 1'b0;
      if (i == 10) begin
        rst_n = 1'b1;
        btnC  = 1'b0;
      end
    end

    for (int k = 0; k < 200 && q.size() > 0; k++) tick;
    while (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: check for cycle %0d never evaluated", sel_name(q[0].sel), q[0].cyc);
      q.delete(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
